// File: rtl/debounce_timer_pkg.sv
// Shared millisecond-timing defaults and width helpers for the board-input timers.
// Any other ms-based timer in the design imports this package.
package debounce_timer_pkg;

    localparam int unsigned CLK_HZ_DEFAULT      = 100_000_000;
    localparam int unsigned TICK_HZ_DEFAULT     = 1000;
    localparam int unsigned DEBOUNCE_MS_DEFAULT = 16;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Width of a counter that must reach terminal_count inclusive, at least one bit.
    function automatic int unsigned count_width(input int unsigned terminal_count);
        int unsigned w;
        w = clog2(terminal_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_timer_ch.sv
// One debouncer channel: saturating millisecond counter cleared by rc and advanced by the shared
// tick while enc is high; ms_16 flags that the terminal count has been reached.
module debounce_timer_ch
    import debounce_timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic rc,
    input  logic enc,
    output logic ms_16
);

    localparam int unsigned CW = count_width(DEBOUNCE_MS);
    localparam logic [CW-1:0] TERM_CNT = CW'(DEBOUNCE_MS);

    logic [CW-1:0] r_cnt;
    logic          w_below_term;

    assign w_below_term = (r_cnt < TERM_CNT);

    // Clear beats everything; stops at the terminal count so the flag can be held as a level.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!rc) begin
            r_cnt <= '0;
        end else if (enc && tick && w_below_term) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign ms_16 = (r_cnt == TERM_CNT);

endmodule

// File: rtl/debounce_timer.sv
// Shared 1 ms prescaler plus one saturating timeout counter per debouncer channel.
// The prescaler free-runs and is not aligned to any channel's start.
module debounce_timer
    import debounce_timer_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ     = TICK_HZ_DEFAULT,
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] rc,
    input  logic [NUM_CH-1:0] enc,
    output logic [NUM_CH-1:0] ms_16,
    output logic [NUM_CH-1:0] busy,
    output logic              tick_1ms
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    if (DIV < 2 || DEBOUNCE_MS < 1) begin : g_param_check
        $error("debounce_timer: CLK_HZ/TICK_HZ must be >= 2 and DEBOUNCE_MS >= 1");
    end

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          w_presc_last;

    assign w_presc_last = (r_presc == PRESC_LAST);

    // Tick is registered so it is a clean one-cycle pulse following the last prescaler count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= w_presc_last;
            r_presc <= w_presc_last ? '0 : r_presc + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_timer_ch #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_ch (
            .clk  (clk),
            .rstn (rstn),
            .tick (r_tick),
            .rc   (rc[i]),
            .enc  (enc[i]),
            .ms_16(ms_16[i])
        );
    end

    assign busy     = rc & enc & ~ms_16;
    assign tick_1ms = r_tick;

endmodule
